// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: widths, state
// encoding, opcodes, instruction classes and datapath mux codes.
package multicycle_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int ST_W    = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  typedef enum logic [2:0] {
    CL_R, CL_MEM, CL_BR, CL_IMM, CL_J, CL_ILL
  } iclass_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle; master = controller, slave = datapath side.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OP_W-1:0] instr_op_i;
  logic            zero_i;
  logic            mem_ready_i;
  logic            pc_write_o;
  logic            ir_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            iord_o;
  logic            reg_write_o;
  logic            reg_dst_o;
  logic            mem_to_reg_o;
  logic            alu_src_a_o;
  logic [1:0]      alu_src_b_o;
  logic [1:0]      alu_op_o;
  logic [1:0]      pc_src_o;
  logic            ext_sel_o;
  logic [ST_W-1:0] state_o;
  logic            illegal_o;

  modport master (
    input  instr_op_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, ext_sel_o, state_o, illegal_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, ext_sel_o, state_o, illegal_o
  );

endinterface

// File: rtl/multicycle_ctrl_opdec.sv
// Opcode classifier: instruction class, immediate extension mode, legality.
// Purely combinational.
module multicycle_ctrl_opdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  output iclass_t         o_class,
  output logic            o_ext_sel,
  output logic            o_legal
);

  always_comb begin
    o_class   = CL_ILL;
    o_ext_sel = 1'b1;
    o_legal   = 1'b1;
    case (i_op)
      OP_RTYPE:                 o_class = CL_R;
      OP_LW, OP_SW:             o_class = CL_MEM;
      OP_BEQ, OP_BNE:           o_class = CL_BR;
      OP_ADDI, OP_SLTI:         o_class = CL_IMM;
      OP_ORI: begin
        o_class   = CL_IMM;
        o_ext_sel = 1'b0;
      end
      OP_J:                     o_class = CL_J;
      default:                  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM driving all datapath enables and muxes.
// Define MULTICYCLE_CTRL_TRAP_HALT_EN to make TRAP terminal until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_ctrl_if.master   bus
);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op_q;
  logic [OP_W-1:0] w_dec_op;
  iclass_t         w_class;
  logic            w_dec_ext;
  logic            w_legal;

  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_iord;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
  logic       w_ext_sel, w_illegal;

  // DECODE classifies the live IR; later states see only the latched opcode.
  assign w_dec_op = (r_state == S_DECODE) ? bus.instr_op_i : r_op_q;

  multicycle_ctrl_opdec u_opdec (
    .i_op      (w_dec_op),
    .o_class   (w_class),
    .o_ext_sel (w_dec_ext),
    .o_legal   (w_legal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= bus.instr_op_i;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_alu_op     = ALU_ADD;
    w_pc_src     = PCSRC_ALU;
    w_ext_sel    = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_4;
        if (bus.mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM_SH;
        w_ext_sel   = 1'b1;
        if (!w_legal) w_next = S_TRAP;
        else begin
          case (w_class)
            CL_R:    w_next = S_R_EXEC;
            CL_MEM:  w_next = S_MEM_ADDR;
            CL_BR:   w_next = S_BRANCH;
            CL_IMM:  w_next = S_I_EXEC;
            CL_J:    w_next = S_JUMP;
            default: w_next = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_ext_sel   = 1'b1;
        w_next      = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready_i) w_next = S_FETCH;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
        w_next      = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALU_OPC;
        w_ext_sel   = w_dec_ext;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
        w_ext_sel   = w_dec_ext;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_SUB;
        w_pc_src    = PCSRC_ALUOUT;
        w_pc_write  = (r_op_q == OP_BEQ) ? bus.zero_i : ~bus.zero_i;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_JUMP;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_HALT_EN
        w_next    = S_TRAP;
`else
        w_next    = S_FETCH;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.pc_write_o   = w_pc_write;
  assign bus.ir_write_o   = w_ir_write;
  assign bus.mem_read_o   = w_mem_read;
  assign bus.mem_write_o  = w_mem_write;
  assign bus.iord_o       = w_iord;
  assign bus.reg_write_o  = w_reg_write;
  assign bus.reg_dst_o    = w_reg_dst;
  assign bus.mem_to_reg_o = w_mem_to_reg;
  assign bus.alu_src_a_o  = w_alu_src_a;
  assign bus.alu_src_b_o  = w_alu_src_b;
  assign bus.alu_op_o     = w_alu_op;
  assign bus.pc_src_o     = w_pc_src;
  assign bus.ext_sel_o    = w_ext_sel;
  assign bus.state_o      = r_state;
  assign bus.illegal_o    = w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, per-class sequencing, memory
// stalls, branch conditions, extender mode and illegal-opcode handling.
module tb_multicycle_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] w_outs;
  assign w_outs = {bus.pc_write_o, bus.ir_write_o, bus.mem_read_o, bus.mem_write_o,
                   bus.iord_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
                   bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_src_o,
                   bus.ext_sel_o, bus.illegal_o};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // From FETCH: present opcode with memory ready, step into DECODE.
  task automatic fetch_decode(input logic [5:0] op);
    bus.instr_op_i  = op;
    bus.mem_ready_i = 1'b1;
    settle();
    check("fetch_state", 32'(bus.state_o), 32'd1);
    check("fetch_irw", 32'(bus.ir_write_o), 32'd1);
    check("fetch_pcw", 32'(bus.pc_write_o), 32'd1);
    tick();
    check("decode_state", 32'(bus.state_o), 32'd2);
    check("decode_srcb", 32'(bus.alu_src_b_o), 32'd3);
    check("decode_ext", 32'(bus.ext_sel_o), 32'd1);
  endtask

  // Leave DECODE and scramble the IR so later states must rely on the latch.
  task automatic leave_decode();
    tick();
    bus.instr_op_i = 6'h3F;
    settle();
  endtask

  int pcw;

  initial begin
    rst_i           = 1'b1;
    bus.instr_op_i  = 6'h00;
    bus.zero_i      = 1'b0;
    bus.mem_ready_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_outs", 32'(w_outs), 32'd0);
    tick();
    check("idle_to_fetch", 32'(bus.state_o), 32'd1);

    // Reset while stalled in MEM_RD
    fetch_decode(6'h23);
    leave_decode();
    check("madr_state", 32'(bus.state_o), 32'd3);
    tick();
    bus.mem_ready_i = 1'b0;
    settle();
    check("mrd_state", 32'(bus.state_o), 32'd4);
    tick();
    rst_i = 1'b1;
    settle();
    check("mrd_hold", 32'(bus.mem_read_o), 32'd1);
    tick();
    check("rst_mid_state", 32'(bus.state_o), 32'd0);
    check("rst_mid_outs", 32'(w_outs), 32'd0);
    tick();
    rst_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    settle();
    check("rst2_state", 32'(bus.state_o), 32'd0);
    tick();
    check("post_rst_state", 32'(bus.state_o), 32'd1);
    check("post_rst_mrd", 32'(bus.mem_read_o), 32'd1);

    // FETCH stall
    bus.mem_ready_i = 1'b0;
    settle();
    check("fstall_pcw", 32'(bus.pc_write_o), 32'd0);
    check("fstall_irw", 32'(bus.ir_write_o), 32'd0);
    tick();
    check("fstall_state", 32'(bus.state_o), 32'd1);

    // R-type add
    pcw = 1;
    fetch_decode(6'h00);
    pcw += int'(bus.pc_write_o);
    leave_decode();
    check("rexec_state", 32'(bus.state_o), 32'd7);
    check("rexec_aluop", 32'(bus.alu_op_o), 32'd2);
    check("rexec_srca", 32'(bus.alu_src_a_o), 32'd1);
    pcw += int'(bus.pc_write_o);
    tick();
    check("rwb_state", 32'(bus.state_o), 32'd8);
    check("rwb_regw", 32'(bus.reg_write_o), 32'd1);
    check("rwb_regdst", 32'(bus.reg_dst_o), 32'd1);
    pcw += int'(bus.pc_write_o);
    check("add_pcw_pulses", 32'(pcw), 32'd1);
    tick();
    check("add_done", 32'(bus.state_o), 32'd1);

    // lw with three stall cycles
    fetch_decode(6'h23);
    leave_decode();
    check("lw_madr_srcb", 32'(bus.alu_src_b_o), 32'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready_i = (i == 3);
      settle();
      check("lw_mrd_state", 32'(bus.state_o), 32'd4);
      check("lw_mrd_iord", 32'(bus.iord_o), 32'd1);
      tick();
    end
    check("lw_mwb_state", 32'(bus.state_o), 32'd5);
    check("lw_mwb_m2r", 32'(bus.mem_to_reg_o), 32'd1);
    check("lw_mwb_regw", 32'(bus.reg_write_o), 32'd1);
    tick();
    check("lw_done", 32'(bus.state_o), 32'd1);

    // sw
    fetch_decode(6'h2B);
    leave_decode();
    tick();
    check("sw_state", 32'(bus.state_o), 32'd6);
    check("sw_rw", 32'({bus.mem_write_o, bus.mem_read_o}), 32'd2);
    tick();
    check("sw_done", 32'(bus.state_o), 32'd1);

    // beq / bne with zero set
    fetch_decode(6'h04);
    bus.zero_i = 1'b1;
    leave_decode();
    check("beq_state", 32'(bus.state_o), 32'd11);
    check("beq_pcw", 32'(bus.pc_write_o), 32'd1);
    check("beq_pcsrc", 32'(bus.pc_src_o), 32'd1);
    check("beq_aluop", 32'(bus.alu_op_o), 32'd1);
    tick();
    fetch_decode(6'h05);
    leave_decode();
    check("bne_pcw_z1", 32'(bus.pc_write_o), 32'd0);
    check("bne_pcsrc", 32'(bus.pc_src_o), 32'd1);
    bus.zero_i = 1'b0;
    settle();
    check("bne_pcw_z0", 32'(bus.pc_write_o), 32'd1);
    tick();

    // ori then addi
    fetch_decode(6'h0D);
    leave_decode();
    check("ori_exec_state", 32'(bus.state_o), 32'd9);
    check("ori_exec_ext", 32'(bus.ext_sel_o), 32'd0);
    check("ori_exec_aluop", 32'(bus.alu_op_o), 32'd3);
    tick();
    check("ori_wb_state", 32'(bus.state_o), 32'd10);
    check("ori_wb_ext", 32'(bus.ext_sel_o), 32'd0);
    tick();
    fetch_decode(6'h08);
    leave_decode();
    check("addi_exec_ext", 32'(bus.ext_sel_o), 32'd1);
    check("addi_exec_aluop", 32'(bus.alu_op_o), 32'd3);
    tick();
    check("addi_wb_ext", 32'(bus.ext_sel_o), 32'd1);
    tick();

    // j
    fetch_decode(6'h02);
    leave_decode();
    check("j_state", 32'(bus.state_o), 32'd12);
    check("j_pc", 32'({bus.pc_write_o, bus.pc_src_o}), 32'h6);
    tick();
    check("j_done", 32'(bus.state_o), 32'd1);

    // Illegal opcode
    fetch_decode(6'h3F);
    leave_decode();
    check("trap_state", 32'(bus.state_o), 32'd13);
    check("trap_ill", 32'(bus.illegal_o), 32'd1);
`ifdef MULTICYCLE_CTRL_TRAP_HALT_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      check("trap_hold", 32'({bus.state_o, w_outs}), 32'({4'd13, 17'd1}));
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check("trap_rst", 32'(bus.state_o), 32'd0);
`else
    tick();
    check("trap_next", 32'(bus.state_o), 32'd1);
    check("trap_ill_drop", 32'(bus.illegal_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
